dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port data memory.

- Shares the memory between the core load/store path (port 0) and a loader/DMA agent (port 1), using round-robin arbitration.
- Runs one transaction at a time and drives the memory's address, write-data and write-enable lines.
- Captures the memory's combinational read data into a registered response with range checking.
- Sits between the pipeline's memory stage, the loader, and the data memory.

---
 rtl/dmem_arbiter_if.sv | 44 ++++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface dmem_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m0_err;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output mem_a, mem_wd, mem_we,
        input  mem_rd
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  mem_a, mem_wd, mem_we,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing the single-port data memory between the core (port 0)
// and the loader (port 1); one transaction at a time, registered responses with range check.
module dmem_arbiter #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q;
    logic        last_q;
    logic        id_q;
    logic        we_q;
    logic        oor_q;
    logic        gnt0_q, gnt1_q;
    logic        rvalid0_q, rvalid1_q;
    logic        err0_q, err1_q;
    logic [31:0] rdata0_q, rdata1_q;
    logic [31:0] mem_a_q, mem_wd_q;
    logic        mem_we_q;

    logic        any_req;
    logic        win;
    logic        sel_we;
    logic        sel_oor;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] rd_cap;

    always_comb begin
        any_req   = bus.m0_req | bus.m1_req;
        // On a tie the port not granted last wins; otherwise the lone requester.
        win       = (bus.m0_req & bus.m1_req) ? ~last_q : bus.m1_req;
        sel_we    = win ? bus.m1_we    : bus.m0_we;
        sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;
        sel_oor   = (sel_addr >= DEPTH);
        rd_cap    = (!we_q && !oor_q) ? bus.mem_rd : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            mem_a_q   <= '0;
            mem_wd_q  <= '0;
            mem_we_q  <= 1'b0;
        end else begin
            // Pulsed outputs and the memory drive are only ever live for one cycle.
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            mem_a_q   <= '0;
            mem_wd_q  <= '0;
            mem_we_q  <= 1'b0;
            case (state_q)
                StIdle, StResp: begin
                    if (any_req) begin
                        id_q     <= win;
                        we_q     <= sel_we;
                        oor_q    <= sel_oor;
                        last_q   <= win;
                        gnt0_q   <= ~win;
                        gnt1_q   <= win;
                        mem_a_q  <= sel_addr;
                        mem_wd_q <= sel_wdata;
                        mem_we_q <= sel_we & ~sel_oor;
                        state_q  <= StAccess;
                    end else begin
                        state_q  <= StIdle;
                    end
                end
                StAccess: begin
                    if (id_q) begin
                        rvalid1_q <= 1'b1;
                        rdata1_q  <= rd_cap;
                        err1_q    <= oor_q;
                    end else begin
                        rvalid0_q <= 1'b1;
                        rdata0_q  <= rd_cap;
                        err0_q    <= oor_q;
                    end
                    state_q <= StResp;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.m0_gnt    = gnt0_q;
    assign bus.m1_gnt    = gnt1_q;
    assign bus.m0_rvalid = rvalid0_q;
    assign bus.m1_rvalid = rvalid1_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.m0_err    = err0_q;
    assign bus.m1_err    = err1_q;
    assign bus.mem_a     = mem_a_q;
    assign bus.mem_wd    = mem_wd_q;
    assign bus.mem_we    = mem_we_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grant/response cycles
// and data; a separate monitor compares the DUT against those predictions every cycle.
module tb_dmem_arbiter;
    localparam int unsigned DEPTH = 1024;
    localparam int AW = $clog2(DEPTH);

    typedef struct {
        int          cyc;
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    item_t gq[$];
    item_t rq[$];

    logic [31:0] tb_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    dmem_arbiter_if bus ();

    dmem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int i);
        return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural data memory: combinational read, write on the rising edge.
    assign bus.mem_rd = (bus.mem_a < DEPTH) ? tb_mem[bus.mem_a[AW-1:0]] : 32'h0;
    initial begin
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (bus.mem_we === 1'b1 && bus.mem_a < DEPTH) tb_mem[bus.mem_a[AW-1:0]] = bus.mem_wd;
        end
    end

    // Reference model: at most one decision every other cycle, round-robin on ties,
    // writes become visible to the next decision.
    initial begin
        int          busy;
        logic        last;
        logic        pend;
        logic [31:0] paddr, pdata;
        item_t       it;
        busy = 0; last = 1'b1; pend = 1'b0; paddr = 0; pdata = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (!rst) begin
                gq.delete(); rq.delete();
                busy = 0; last = 1'b1; pend = 1'b0;
            end else if (busy != 0) begin
                busy = 0;
            end else begin
                if (pend) begin
                    ref_mem[paddr[AW-1:0]] = pdata;
                    pend = 1'b0;
                end
                if (bus.m0_req || bus.m1_req) begin
                    if (bus.m0_req && bus.m1_req) it.port = !last;
                    else it.port = bus.m1_req;
                    last     = it.port;
                    it.we    = it.port ? bus.m1_we : bus.m0_we;
                    it.addr  = it.port ? bus.m1_addr : bus.m0_addr;
                    it.wdata = it.port ? bus.m1_wdata : bus.m0_wdata;
                    it.err   = (it.addr >= DEPTH);
                    it.rdata = (!it.we && !it.err) ? ref_mem[it.addr[AW-1:0]] : 32'h0;
                    if (it.we && !it.err) begin
                        pend = 1'b1; paddr = it.addr; pdata = it.wdata;
                    end
                    it.cyc = cyc + 1;
                    gq.push_back(it);
                    it.cyc = cyc + 2;
                    rq.push_back(it);
                    busy = 1;
                end
            end
        end
    end

    // Monitor: compares every cycle against whatever the model scheduled for it.
    initial begin
        item_t       it;
        logic [1:0]  eg, ev;
        logic [31:0] ea, ewd;
        logic        ewe;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("reset pulses/err", {26'b0, bus.m1_gnt, bus.m0_gnt, bus.m1_rvalid,
                      bus.m0_rvalid, bus.m1_err, bus.m0_err}, 32'h0);
                check("reset m0_rdata", bus.m0_rdata, 32'h0);
                check("reset m1_rdata", bus.m1_rdata, 32'h0);
                check("reset mem_a", bus.mem_a, 32'h0);
                check("reset mem_wd", bus.mem_wd, 32'h0);
                check("reset mem_we", {31'b0, bus.mem_we}, 32'h0);
            end else begin
                eg = 2'b00; ea = 0; ewd = 0; ewe = 1'b0;
                if (gq.size() > 0 && gq[0].cyc == cyc) begin
                    it = gq.pop_front();
                    eg[it.port] = 1'b1;
                    ea = it.addr; ewd = it.wdata; ewe = it.we & !it.err;
                end
                check("gnt", {30'b0, bus.m1_gnt, bus.m0_gnt}, {30'b0, eg});
                check("mem_a", bus.mem_a, ea);
                check("mem_wd", bus.mem_wd, ewd);
                check("mem_we", {31'b0, bus.mem_we}, {31'b0, ewe});
                ev = 2'b00;
                if (rq.size() > 0 && rq[0].cyc == cyc) begin
                    it = rq.pop_front();
                    ev[it.port] = 1'b1;
                    if (it.port) begin
                        check("m1_rdata", bus.m1_rdata, it.rdata);
                        check("m1_err", {31'b0, bus.m1_err}, {31'b0, it.err});
                    end else begin
                        check("m0_rdata", bus.m0_rdata, it.rdata);
                        check("m0_err", {31'b0, bus.m0_err}, {31'b0, it.err});
                    end
                end
                check("rvalid", {30'b0, bus.m1_rvalid, bus.m0_rvalid}, {30'b0, ev});
            end
        end
    end

    // Issue one request at posedge+1 and hold it until the edge that ends its gnt cycle.
    task automatic txn(input logic p, input logic we, input logic [31:0] a, input logic [31:0] d);
        int   n;
        logic got;
        n = 0; got = 1'b0;
        if (p) begin
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
        end else begin
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
        end
        while (!got && n < 40) begin
            @(negedge clk);
            got = p ? bus.m1_gnt : bus.m0_gnt;
            n++;
        end
        check("gnt wait", {31'b0, got}, 32'h1);
        @(posedge clk);
        #1;
        if (p) bus.m1_req = 1'b0;
        else bus.m0_req = 1'b0;
    endtask

    task automatic rand_txn(input logic p);
        int          g;
        logic [31:0] a;
        g = $urandom_range(0, 3);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        if ($urandom_range(0, 9) == 0)
            a = ($urandom_range(0, 1) == 0) ? 32'(DEPTH + $urandom_range(0, 5)) : 32'hFFFF_FFF0;
        else
            a = $urandom_range(0, 31);
        txn(p, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Port 0 write then read back.
        @(posedge clk); #1;
        txn(0, 1'b1, 32'd28, 32'h0000_0020);
        check("write rdata", bus.m0_rdata, 32'h0);
        check("write err", {31'b0, bus.m0_err}, 32'h0);
        txn(0, 1'b0, 32'd28, 32'h0);
        check("read back 28", bus.m0_rdata, 32'h0000_0020);

        // Both ports requesting continuously: alternating grants every 2 cycles.
        fork
            begin
                for (int i = 0; i < 4; i++) txn(0, 1'b0, 32'(100 + i), 32'h0);
            end
            begin
                for (int i = 0; i < 4; i++) txn(1, 1'b1, 32'(200 + i), 32'(i + 7));
            end
        join

        // Out-of-range write must not touch memory.
        txn(1, 1'b1, 32'd1024, 32'hDEAD_BEEF);
        check("oor err", {31'b0, bus.m1_err}, 32'h1);
        check("oor rdata", bus.m1_rdata, 32'h0);
        txn(0, 1'b0, 32'd0, 32'h0);
        check("addr 0 unchanged", bus.m0_rdata, init_val(0));

        // Port 0 re-requests in its response cycle with port 1 idle.
        txn(0, 1'b1, 32'd40, 32'h1234_5678);
        txn(0, 1'b0, 32'd40, 32'h0);
        check("rerequest read", bus.m0_rdata, 32'h1234_5678);

        // Reset during the ACCESS of a write to addr 5.
        repeat (3) @(posedge clk);
        #1;
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'd5; bus.m0_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid reset m0_gnt", {31'b0, bus.m0_gnt}, 32'h0);
        check("mid reset mem_we", {31'b0, bus.mem_we}, 32'h0);
        check("mid reset mem_a", bus.mem_a, 32'h0);
        bus.m0_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        fork
            txn(0, 1'b0, 32'd5, 32'h0);
            txn(1, 1'b0, 32'd6, 32'h0);
        join
        check("dropped write", bus.m0_rdata, init_val(5));
        check("tie read 6", bus.m1_rdata, init_val(6));

        // Randomized traffic from both ports.
        fork
            begin
                for (int i = 0; i < 60; i++) rand_txn(0);
            end
            begin
                for (int i = 0; i < 60; i++) rand_txn(1);
            end
        join

        repeat (6) @(negedge clk);
        check("gnt queue drained", gq.size(), 32'h0);
        check("rvalid queue drained", rq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
